// File: rtl/verencode.sv
// RV32I instruction encoder: field-level requests in, 32-bit words out on a
// valid/ready stream. LI expands to LUI+ADDI when the constant needs both.
module verencode #(
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_kind,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [2:0]  req_funct3,
   input  logic        req_alt,
   input  logic [31:0] req_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        out_error
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic {IDLE, SECOND} state_t;
   state_t state;

   logic [31:0] imm;
   logic [31:0] enc_word, enc_pend, pend;
   logic        enc_last, enc_err, enc_two;
   logic        fit12, fit13, fit21;
   logic [19:0] li_hi;
   logic [6:0]  i_opc;

   assign imm   = req_imm;
   // Signed-range tests: all bits above the field's sign bit equal the sign bit.
   assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
   assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);
   // Upper part rounded so that ADDI's sign-extended low 12 bits land exactly.
   assign li_hi = imm[31:12] + {19'd0, imm[11]};
   assign i_opc = (req_kind == 4'd2) ? OPC_LOAD : (req_kind == 4'd8) ? OPC_JALR : OPC_OPIMM;

   assign req_ready = (state == IDLE) && (!out_valid || out_ready);

   always_comb begin
      enc_word = NOP_WORD;
      enc_pend = NOP_WORD;
      enc_last = 1'b1;
      enc_err  = 1'b0;
      enc_two  = 1'b0;
      case (req_kind)
         4'd0: enc_word = {1'b0, req_alt, 5'd0, req_rs2, req_rs1, req_funct3, req_rd, OPC_OP};
         4'd1, 4'd2, 4'd8: begin
            if (req_kind == 4'd1 && req_funct3[1:0] == 2'b01) begin
               enc_word = {1'b0, req_alt, 5'd0, imm[4:0], req_rs1, req_funct3, req_rd, OPC_OPIMM};
               enc_err  = |imm[31:5];
            end else begin
               enc_word = {imm[11:0], req_rs1, req_funct3, req_rd, i_opc};
               enc_err  = !fit12;
            end
         end
         4'd3: begin
            enc_word = {imm[11:5], req_rs2, req_rs1, req_funct3, imm[4:0], OPC_STORE};
            enc_err  = !fit12;
         end
         4'd4: begin
            enc_word = {imm[12], imm[10:5], req_rs2, req_rs1, req_funct3, imm[4:1], imm[11], OPC_BRANCH};
            enc_err  = !fit13 | imm[0];
         end
         4'd5, 4'd6: begin
            enc_word = {imm[31:12], req_rd, (req_kind == 4'd5) ? OPC_LUI : OPC_AUIPC};
            enc_err  = |imm[11:0];
         end
         4'd7: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], req_rd, OPC_JAL};
            enc_err  = !fit21 | imm[0];
         end
         4'd9: begin
            enc_word = {imm[11:0], 5'd0, 3'd0, 5'd0, OPC_SYSTEM};
            enc_err  = |imm[31:12];
         end
         4'd10: begin
            if (fit12) begin
               enc_word = {imm[11:0], 5'd0, 3'd0, req_rd, OPC_OPIMM};
            end else if (imm[11:0] == 12'd0) begin
               enc_word = {imm[31:12], req_rd, OPC_LUI};
            end else begin
               enc_word = {li_hi, req_rd, OPC_LUI};
               enc_pend = {imm[11:0], req_rd, 3'd0, req_rd, OPC_OPIMM};
               enc_last = 1'b0;
               enc_two  = 1'b1;
            end
         end
         default: enc_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= 32'd0;
         out_last  <= 1'b0;
         out_error <= 1'b0;
         pend      <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  out_valid <= 1'b1;
                  out_data  <= enc_word;
                  out_last  <= enc_last;
                  out_error <= enc_err;
                  pend      <= enc_pend;
                  if (enc_two) state <= SECOND;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            SECOND: begin
               // LUI consumed: ADDI follows with no bubble.
               if (out_ready) begin
                  out_data  <= pend;
                  out_last  <= 1'b1;
                  out_error <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_verencode.sv
// Bench for verencode: directed encodings, LI stall/reset cases, and random
// traffic scored against an arithmetic reference model.
module tb_verencode;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [3:0]  req_kind;
   logic [4:0]  req_rd, req_rs1, req_rs2;
   logic [2:0]  req_funct3;
   logic        req_alt;
   logic [31:0] req_imm;
   logic        out_valid, out_ready, out_last, out_error;
   logic [31:0] out_data;

   int checks = 0;
   int errors = 0;

   verencode dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_funct3(req_funct3), .req_alt(req_alt), .req_imm(req_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_error(out_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected stream entries are {last, err, word}.
   logic [33:0] q[$];

   function automatic void model_push(input logic [3:0] k, input logic [4:0] rd, rs1, rs2,
                                      input logic [2:0] f3, input logic alt, input logic [31:0] imm);
      longint s;
      logic [31:0] w, hi;
      logic e;
      s = longint'($signed(imm));
      e = 1'b0;
      w = 32'h00000013;
      case (k)
         0: w = {alt ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
         1, 2, 8: begin
            if (k == 1 && (f3 == 3'b001 || f3 == 3'b101)) begin
               w = {alt ? 7'h20 : 7'h00, imm[4:0], rs1, f3, rd, 7'h13};
               e = (s < 0 || s > 31);
            end else begin
               w = {imm[11:0], rs1, f3, rd, (k == 1) ? 7'h13 : (k == 2) ? 7'h03 : 7'h67};
               e = (s < -2048 || s > 2047);
            end
         end
         3: begin
            w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
            e = (s < -2048 || s > 2047);
         end
         4: begin
            w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
            e = (s < -4096 || s > 4094 || imm[0]);
         end
         5, 6: begin
            w = {imm[31:12], rd, (k == 5) ? 7'h37 : 7'h17};
            e = ((imm & 32'hFFF) != 0);
         end
         7: begin
            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
            e = (s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 2 || imm[0]);
         end
         9: begin
            w = {imm[11:0], 20'h00073};
            e = (s < 0 || s > 4095);
         end
         10: begin
            if (s >= -2048 && s <= 2047) begin
               w = {imm[11:0], 5'd0, 3'd0, rd, 7'h13};
            end else if ((imm & 32'hFFF) == 0) begin
               w = {imm[31:12], rd, 7'h37};
            end else begin
               hi = (imm + 32'h800) >> 12;
               q.push_back({1'b0, 1'b0, hi[19:0], rd, 7'h37});
               w = {imm[11:0], rd, 3'd0, rd, 7'h13};
            end
         end
         default: e = 1'b1;
      endcase
      q.push_back({1'b1, e, w});
   endfunction

   // Scoreboard and hold-while-stalled monitor.
   logic        prev_stall = 1'b0;
   logic [33:0] prev_out;
   logic [33:0] exp_e;
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 34'(out_valid), 34'd1);
            chk("hold_data", {out_last, out_error, out_data}, prev_out);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("extra_word", 34'(out_valid), 34'd0);
            else begin
               exp_e = q.pop_front();
               chk("sb_word", {out_last, out_error, out_data}, exp_e);
            end
         end
         if (req_valid && req_ready)
            model_push(req_kind, req_rd, req_rs1, req_rs2, req_funct3, req_alt, req_imm);
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_last, out_error, out_data};
      end
   end

   task automatic set_req(input logic [3:0] k, input logic [4:0] rd, rs1, rs2,
                          input logic [2:0] f3, input logic alt, input logic [31:0] imm);
      req_kind = k; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
      req_funct3 = f3; req_alt = alt; req_imm = imm;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [3:0] k, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic alt, input logic [31:0] imm);
      int n;
      set_req(k, rd, rs1, rs2, f3, alt, imm);
      req_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("accept_timeout", 34'(req_ready), 34'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic dir(input string tag, input logic [3:0] k, input logic [4:0] rd, rs1, rs2,
                      input logic [2:0] f3, input logic alt, input logic [31:0] imm,
                      input logic [31:0] ew, input logic el, input logic ee);
      send(k, rd, rs1, rs2, f3, alt, imm);
      @(negedge clk);
      chk({tag, "_valid"}, 34'(out_valid), 34'd1);
      chk(tag, {out_last, out_error, out_data}, {el, ee, ew});
      @(posedge clk); #1;
   endtask

   int edges[18] = '{-2048, 2047, 2048, -2049, 4094, 4095, -4096, -4098, 31, 32,
                     0, 1, 1048574, -1048576, 1048576, 4096, 32'h12345000, -1};

   function automatic logic [31:0] rand_imm();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 80)) - 32'd40;
         1: return $urandom;
         2: return edges[$urandom_range(0, 17)];
         default: return $urandom & 32'hFFFFF000;
      endcase
   endfunction

   initial begin
      reset = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
      set_req(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 34'(out_valid), 34'd0);
      chk("rst_out", {out_last, out_error, out_data}, 34'd0);
      chk("rst_ready", 34'(req_ready), 34'd1);
      @(posedge clk); #1;
      reset = 1'b0; out_ready = 1'b1;

      dir("add",   0, 3, 1, 2, 0, 0, 0,           32'h002081B3, 1, 0);
      dir("sub",   0, 3, 1, 2, 0, 1, 0,           32'h402081B3, 1, 0);
      dir("addi",  1, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 1, 0);
      dir("sw",    3, 0, 1, 2, 2, 0, 4,           32'h0020A223, 1, 0);
      dir("beq8",  4, 0, 1, 2, 0, 0, 8,           32'h00208463, 1, 0);
      dir("beq3",  4, 0, 1, 2, 0, 0, 3,           32'h00208163, 1, 1);
      dir("ecall", 9, 7, 7, 0, 3, 0, 0,           32'h00000073, 1, 0);
      dir("ebrk",  9, 0, 0, 0, 0, 0, 1,           32'h00100073, 1, 0);
      dir("csr",   9, 0, 0, 0, 0, 0, 32'h302,     32'h30200073, 1, 0);
      dir("illeg", 12, 1, 1, 1, 0, 0, 0,          32'h00000013, 1, 1);
      dir("li_sm", 10, 5, 0, 0, 0, 0, -5,         32'hFFB00293, 1, 0);

      // Two-word LI with the consumer stalled between words.
      repeat (2) @(posedge clk); #1;
      out_ready = 1'b0;
      send(10, 5, 0, 0, 0, 0, 32'h12345FFF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("li_lui", {out_valid, out_last, out_error, out_data}, {1'b1, 1'b0, 1'b0, 32'h123462B7});
         chk("li_rdy0", 34'(req_ready), 34'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("li_rdy1", 34'(req_ready), 34'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("li_addi", {out_valid, out_last, out_error, out_data}, {1'b1, 1'b1, 1'b0, 32'hFFF28293});
      @(posedge clk); #1;
      @(negedge clk);
      chk("li_drop", 34'(out_valid), 34'd0);
      @(posedge clk); #1;

      // Reset while the ADDI is pending.
      out_ready = 1'b0;
      send(10, 5, 0, 0, 0, 0, 32'h12345FFF);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rs2_valid", 34'(out_valid), 34'd0);
      chk("rs2_ready", 34'(req_ready), 34'd1);
      @(posedge clk); #1;
      reset = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rs2_noaddi", 34'(out_valid), 34'd0);
         @(posedge clk); #1;
      end

      // Back-to-back OP stream.
      for (int i = 0; i < 20; i++) begin
         set_req(0, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), 0);
         req_valid = 1'b1;
         @(negedge clk);
         chk("b2b_ready", 34'(req_ready), 34'd1);
         if (i > 0) chk("b2b_valid", 34'(out_valid), 34'd1);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;

      // Random traffic with random back-pressure.
      for (int i = 0; i < 600; i++) begin
         set_req(4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 1'($urandom), rand_imm());
         req_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("drain", 34'(q.size()), 34'd0);
      chk("drain_valid", 34'(out_valid), 34'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/verencode.md
Name: verencode

Overview:
- Instruction encoder: inverse of the core's instruction decoder.
- Accepts field-level encode requests (kind, registers, funct3, alt bit, full-width immediate) and produces 32-bit RV32I instruction words on a valid/ready stream.
- Expands the LI pseudo-instruction into one or two words and flags out-of-range immediates.
- Sits between the debug/boot program generator and instruction memory or the injection port.

Parameters:
- NOP_WORD, 32'h00000013, word emitted for illegal request kinds (ADDI x0,x0,0).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_kind  in  4  0 OP, 1 OP_IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 SYSTEM, 10 LI; 11-15 illegal.
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_funct3  in  3  funct3 field.
- req_alt  in  1  sets funct7 bit 5 for SUB/SRA (OP) and SRAI (OP_IMM, funct3=101).
- req_imm  in  32  signed full-value immediate (byte offset / constant); for SYSTEM, req_imm[11:0] is funct12.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  32  encoded instruction word.
- out_last  out  1  final word of the current request.
- out_error  out  1  immediate out of range, misaligned, or illegal kind.

Behaviour:
- Reset: out_valid=0, out_data=0, out_last=0, out_error=0, FSM=IDLE. Reset mid-expansion drops the pending word.
- Output is a single register stage. req_ready = (state==IDLE) && (!out_valid || out_ready). Accepted request appears on out_data the next cycle (latency 1). Throughput is 1 word/cycle for single-word requests.
- out_data, out_last and out_error are held stable while out_valid && !out_ready. out_valid drops the cycle after the last word is accepted if no new request is accepted.
- Encoding formats:
  - OP: R-type, opcode 0110011, funct7 = alt<<5.
  - OP_IMM, LOAD, JALR: I-type, opcodes 0010011, 0000011, 1100111.
  - STORE: S-type, 0100011.
  - BRANCH: B-type, 1100011.
  - LUI, AUIPC: U-type, 0110111, 0010111; upper field = req_imm[31:12].
  - JAL: J-type, 1101111.
  - SYSTEM: 1110011; rd, rs1 and funct3 forced 0; imm[11:0] = req_imm[11:0].
- Shift-immediates (OP_IMM with funct3 001/101): imm[4:0] = shamt, imm[11:5] = alt<<5.
- Error rules (word still emitted with truncated fields, out_error=1):
  - I/S: imm outside [-2048,2047].
  - Shift: imm outside [0,31].
  - B: imm outside [-4096,4094] or imm[0]=1.
  - J: outside [-2^20, 2^20-2] or imm[0]=1.
  - U: imm[11:0] != 0.
  - SYSTEM: imm outside [0,4095].
  - Illegal kind: emits NOP_WORD with out_error=1, out_last=1.
- LI (rd, imm) expansion:
  - imm in [-2048,2047]: one word, ADDI rd,x0,imm.
  - imm[11:0]==0: one word, LUI rd,imm[31:12].
  - Otherwise two words: first LUI rd,hi with hi = (imm + 0x800)[31:12] (mod 2^32), out_last=0; then ADDI rd,rd,sext(imm[11:0]), out_last=1.
  - LI never errors.
- FSM:
  - IDLE → SECOND when a two-word LI is accepted; the pending ADDI is held internally.
  - In SECOND, req_ready=0. When the LUI word is accepted, load ADDI into the output register (out_valid stays 1) and return to IDLE.
  - No bubble between the two words.
- Back-pressure in any state stalls without loss or duplication.

Test Plan:
- OP add x3,x1,x2 (alt=0) → 0x002081B3, last=1, err=0; same with alt=1 → 0x402081B3.
- Encode ADDI x1,x0,-1 → 0xFFF00093; SW x2,4(x1) → 0x0020A223; BEQ x1,x2,+8 → 0x00208463; BEQ imm=3 → err=1.
- SYSTEM imm 0, 1, 0x302 → 0x00000073, 0x00100073, 0x30200073; kind=12 → 0x00000013, err=1.
- LI x5,0x12345FFF → 0x123462B7 (last=0), then 0xFFF28293 (last=1), with out_ready low 3 cycles between; req_ready=0 throughout; LI x5,-5 → single 0xFFB00293.
- Back-to-back OP requests with out_ready=1 → one word per cycle, no bubbles; toggling out_ready randomly → no drops or duplicates.
- Assert reset while in SECOND → next cycle out_valid=0, req_ready=1, ADDI never emitted.
